// File: rtl/conv_kxk_acc_pkg.sv
// Shared types and helpers for the KxK convolution accumulator.
// Provides the FSM state enum, clog2, relu, sat_signed and ACC sizing.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        RUN,
        OUT,
        DONE
    } state_e;

    // Post-accumulation math runs at this width so bias add, relu,
    // shift and clamp cannot overflow for any legal ACC_WIDTH < 62.
    localparam int WIDE = 64;
    typedef logic signed [WIDE-1:0] wide_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Smallest accumulator that cannot wrap over K*K*CIN products.
    function automatic int acc_min_width(input int dw, input int k,
                                         input int cin);
        return 2 * dw + clog2(k * k * cin) + 1;
    endfunction

    function automatic wide_t relu(input wide_t v);
        return (v < 0) ? '0 : v;
    endfunction

    function automatic wide_t sat_signed(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_kxk_acc_if.sv
// Stream bundle for conv_kxk_acc: weight load, window input, result out.
// slave = engine side, master = producer/consumer side.
interface conv_kxk_acc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 3,
    parameter int OUT_WIDTH  = 8
) ();

    logic                         weight_valid;
    logic                         weight_ready;
    logic [DATA_WIDTH-1:0]        weight_data;
    logic                         data_valid;
    logic                         data_ready;
    logic [K*K*DATA_WIDTH-1:0]    data_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [OUT_WIDTH-1:0]         out_data;

    modport slave (
        input  weight_valid, weight_data,
        input  data_valid, data_in,
        input  out_ready,
        output weight_ready, data_ready,
        output out_valid, out_data
    );

    modport master (
        output weight_valid, weight_data,
        output data_valid, data_in,
        output out_ready,
        input  weight_ready, data_ready,
        input  out_valid, out_data
    );

endinterface

// File: rtl/conv_kxk_acc_dot.sv
// Combinational signed KxK dot product, full precision, ACC_WIDTH result.
// Ports: w_i / win_i packed K*K signed words (index r*K+c), dot_o sum.
module conv_kxk_dot #(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 3,
    parameter int ACC_WIDTH  = 32
) (
    input  logic [K*K*DATA_WIDTH-1:0]   w_i,
    input  logic [K*K*DATA_WIDTH-1:0]   win_i,
    output logic signed [ACC_WIDTH-1:0] dot_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    logic signed [PW-1:0] p;

    always_comb begin
        dot_o = '0;
        a     = '0;
        b     = '0;
        p     = '0;
        for (int i = 0; i < K * K; i++) begin
            a = {{DATA_WIDTH{w_i[i*DATA_WIDTH+DATA_WIDTH-1]}},
                 w_i[i*DATA_WIDTH +: DATA_WIDTH]};
            b = {{DATA_WIDTH{win_i[i*DATA_WIDTH+DATA_WIDTH-1]}},
                 win_i[i*DATA_WIDTH +: DATA_WIDTH]};
            p = a * b;
            dot_o = dot_o + {{(ACC_WIDTH-PW){p[PW-1]}}, p};
        end
    end

endmodule

// File: rtl/conv_kxk_acc.sv
// KxK multi-channel convolution accumulator: CIN windows -> one pixel.
// Ports: clk, rst (async low), start/keep_weights/pix_count/shift/relu_en
// frame config, busy/done status, bus = weight/window/result streams.
module conv_kxk_acc
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 3,
    parameter int CIN        = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        keep_weights,
    input  logic [15:0] pix_count,
    input  logic [4:0]  shift,
    input  logic        relu_en,
    output logic        busy,
    output logic        done,
    conv_kxk_acc_if.slave bus
);

    localparam int KK = K * K;
    localparam int CW = (CIN > 1) ? clog2(CIN) : 1;
    localparam int PW = (KK > 1) ? clog2(KK) : 1;

    typedef logic [CIN-1:0][KK-1:0][DATA_WIDTH-1:0] wbank_t;

    state_e state_q, state_d;

    wbank_t                       w_q, w_d;
    logic signed [ACC_WIDTH-1:0]  bias_q, bias_d;
    logic [CW-1:0]                wch_q, wch_d;
    logic [PW-1:0]                wpix_q, wpix_d;
    logic                         wbias_q, wbias_d;
    logic                         loaded_q, loaded_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]                ch_q, ch_d;
    logic [15:0]                  pix_idx_q, pix_idx_d;
    logic [15:0]                  pix_cnt_q, pix_cnt_d;
    logic [4:0]                   shift_q, shift_d;
    logic                         relu_q, relu_d;
    logic [OUT_WIDTH-1:0]         out_q, out_d;

    logic signed [ACC_WIDTH-1:0]  dot;
    logic signed [ACC_WIDTH-1:0]  acc_base;
    wide_t                        v;

    conv_kxk_dot #(
        .DATA_WIDTH (DATA_WIDTH),
        .K          (K),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_dot (
        .w_i   (w_q[ch_q]),
        .win_i (bus.data_in),
        .dot_o (dot)
    );

    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign bus.weight_ready = (state_q == LOAD_W);
    assign bus.data_ready   = (state_q == RUN);
    assign bus.out_valid    = (state_q == OUT);
    assign bus.out_data     = out_q;

    // Channel 0 restarts the sum, so the stale accumulator is ignored.
    assign acc_base = (ch_q == '0) ? '0 : acc_q;

    always_comb begin
        v = {{(WIDE-ACC_WIDTH){acc_base[ACC_WIDTH-1]}}, acc_base}
          + {{(WIDE-ACC_WIDTH){dot[ACC_WIDTH-1]}}, dot}
          + {{(WIDE-ACC_WIDTH){bias_q[ACC_WIDTH-1]}}, bias_q};
        if (relu_q) v = relu(v);
        v = v >>> shift_q;
    end

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        bias_d    = bias_q;
        wch_d     = wch_q;
        wpix_d    = wpix_q;
        wbias_d   = wbias_q;
        loaded_d  = loaded_q;
        acc_d     = acc_q;
        ch_d      = ch_q;
        pix_idx_d = pix_idx_q;
        pix_cnt_d = pix_cnt_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        out_d     = out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pix_cnt_d = (pix_count == '0) ? 16'd1 : pix_count;
                    shift_d   = shift;
                    relu_d    = relu_en;
                    pix_idx_d = '0;
                    ch_d      = '0;
                    if (keep_weights && loaded_q) begin
                        state_d = RUN;
                    end else begin
                        state_d  = LOAD_W;
                        loaded_d = 1'b0;
                        wch_d    = '0;
                        wpix_d   = '0;
                        wbias_d  = 1'b0;
                    end
                end
            end
            LOAD_W: begin
                if (bus.weight_valid) begin
                    if (wbias_q) begin
                        bias_d = {{(ACC_WIDTH-DATA_WIDTH)
                                  {bus.weight_data[DATA_WIDTH-1]}},
                                  bus.weight_data};
                        loaded_d = 1'b1;
                        state_d  = RUN;
                    end else begin
                        w_d[wch_q][wpix_q] = bus.weight_data;
                        if (wpix_q == PW'(KK - 1)) begin
                            wpix_d = '0;
                            if (wch_q == CW'(CIN - 1)) wbias_d = 1'b1;
                            else wch_d = wch_q + CW'(1);
                        end else begin
                            wpix_d = wpix_q + PW'(1);
                        end
                    end
                end
            end
            RUN: begin
                if (bus.data_valid) begin
                    acc_d = acc_base + dot;
                    if (ch_q == CW'(CIN - 1)) begin
                        out_d   = OUT_WIDTH'(sat_signed(v, OUT_WIDTH));
                        ch_d    = '0;
                        state_d = OUT;
                    end else begin
                        ch_d = ch_q + CW'(1);
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (pix_idx_q == pix_cnt_q - 16'd1) begin
                        state_d = DONE;
                    end else begin
                        pix_idx_d = pix_idx_q + 16'd1;
                        state_d   = RUN;
                    end
                end
            end
            DONE: begin
                pix_idx_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q       <= '0;
            bias_q    <= '0;
            wch_q     <= '0;
            wpix_q    <= '0;
            wbias_q   <= 1'b0;
            loaded_q  <= 1'b0;
            acc_q     <= '0;
            ch_q      <= '0;
            pix_idx_q <= '0;
            pix_cnt_q <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            out_q     <= '0;
        end else begin
            w_q       <= w_d;
            bias_q    <= bias_d;
            wch_q     <= wch_d;
            wpix_q    <= wpix_d;
            wbias_q   <= wbias_d;
            loaded_q  <= loaded_d;
            acc_q     <= acc_d;
            ch_q      <= ch_d;
            pix_idx_q <= pix_idx_d;
            pix_cnt_q <= pix_cnt_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            out_q     <= out_d;
        end
    end

endmodule

// File: tb/tb_conv_kxk_acc.sv
// Self-checking bench for conv_kxk_acc (K=3, CIN=2) against an
// arithmetic reference model of the convolution pixel.
module tb_conv_kxk_acc;

    localparam int DW   = 8;
    localparam int K    = 3;
    localparam int KK   = K * K;
    localparam int CIN  = 2;
    localparam int OW   = 8;
    localparam int ACCW = 32;
    localparam int TMO  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        keep_weights = 1'b0;
    logic [15:0] pix_count = '0;
    logic [4:0]  shift = '0;
    logic        relu_en = 1'b0;
    logic        busy;
    logic        done;

    conv_kxk_acc_if #(.DATA_WIDTH(DW), .K(K), .OUT_WIDTH(OW)) bus ();

    conv_kxk_acc #(
        .DATA_WIDTH (DW),
        .K          (K),
        .CIN        (CIN),
        .ACC_WIDTH  (ACCW),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .keep_weights (keep_weights),
        .pix_count    (pix_count),
        .shift        (shift),
        .relu_en      (relu_en),
        .busy         (busy),
        .done         (done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ready_cycles = 0;
    int done_cnt = 0;

    int wm[CIN][KK];
    int bm;
    int win[CIN][KK];
    bit model_loaded = 1'b0;
    int cfg_shift;
    bit cfg_relu;
    int last_res;

    always @(negedge clk) begin
        if (bus.weight_ready === 1'b1) ready_cycles++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag,
                         input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    // Pixel value straight from the arithmetic definition.
    function automatic int model();
        longint s;
        s = bm;
        for (int c = 0; c < CIN; c++)
            for (int i = 0; i < KK; i++)
                s += longint'(wm[c][i]) * longint'(win[c][i]);
        if (cfg_relu && s < 0) s = 0;
        s = s >>> cfg_shift;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return int'(s);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic push_weight(input int val);
        int t;
        t = 0;
        bus.weight_valid = 1'b1;
        bus.weight_data  = 8'(val);
        while (bus.weight_ready !== 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) timeout_fail("weight_wait");
        @(negedge clk);
        bus.weight_valid = 1'b0;
    endtask

    task automatic load_weights();
        for (int c = 0; c < CIN; c++)
            for (int i = 0; i < KK; i++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                push_weight(wm[c][i]);
            end
        check("still_loading", bus.weight_ready, 1);
        push_weight(bm);
        check("load_end_wr", bus.weight_ready, 0);
        check("load_end_dr", bus.data_ready, 1);
        model_loaded = 1'b1;
    endtask

    task automatic send_window(input int c);
        int t;
        t = 0;
        for (int i = 0; i < KK; i++)
            bus.data_in[i*DW +: DW] = 8'(win[c][i]);
        bus.data_valid = 1'b1;
        while (bus.data_ready !== 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) timeout_fail("window_wait");
        @(negedge clk);
        bus.data_valid = 1'b0;
    endtask

    task automatic run_frame(input bit keep, input int npix,
                             input int sh, input bit rl,
                             input bit rnd, input int pv,
                             input int hold, input string tag);
        int n;
        int r0;
        int d0;
        int ex;
        bit do_load;
        n = (npix == 0) ? 1 : npix;
        r0 = ready_cycles;
        d0 = done_cnt;
        do_load = !(keep && model_loaded);
        cfg_shift = sh;
        cfg_relu = rl;
        start = 1'b1;
        keep_weights = keep;
        pix_count = 16'(npix);
        shift = 5'(sh);
        relu_en = rl;
        @(negedge clk);
        start = 1'b0;
        keep_weights = 1'b0;
        check({tag, "_busy"}, busy, 1);
        if (do_load) begin
            check({tag, "_load"}, bus.weight_ready, 1);
            load_weights();
        end else begin
            check({tag, "_skip"}, bus.data_ready, 1);
        end
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < CIN; c++)
                for (int i = 0; i < KK; i++)
                    win[c][i] = rnd ? rnd8() : pv;
            ex = model();
            for (int c = 0; c < CIN; c++) send_window(c);
            check({tag, "_ovalid"}, bus.out_valid, 1);
            check({tag, "_data"}, $signed(bus.out_data), ex);
            last_res = int'($signed(bus.out_data));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({tag, "_hold_dr"}, bus.data_ready, 0);
                check({tag, "_hold_d"}, $signed(bus.out_data), ex);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check({tag, "_ov_clr"}, bus.out_valid, 0);
        end
        check({tag, "_done"}, done, 1);
        @(negedge clk);
        check({tag, "_done_1"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_ndone"}, done_cnt - d0, 1);
        if (!do_load) check({tag, "_nowr"}, ready_cycles - r0, 0);
    endtask

    task automatic set_w(input int wv, input int bv);
        for (int c = 0; c < CIN; c++)
            for (int i = 0; i < KK; i++) wm[c][i] = wv;
        bm = bv;
    endtask

    initial begin
        bit kp;
        int d0;
        bus.weight_valid = 1'b0;
        bus.weight_data  = '0;
        bus.data_valid   = 1'b0;
        bus.data_in      = '0;
        bus.out_ready    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr", bus.weight_ready, 0);
        check("rst_dr", bus.data_ready, 0);
        check("rst_ov", bus.out_valid, 0);
        check("rst_od", bus.out_data, 0);
        rst = 1'b1;
        @(negedge clk);

        set_w(1, 0);
        run_frame(1'b1, 1, 0, 1'b0, 1'b0, 2, 0, "ones");
        check("ones_36", last_res, 36);
        run_frame(1'b1, 1, 0, 1'b0, 1'b0, 2, 0, "keep");
        check("keep_36", last_res, 36);
        run_frame(1'b1, 3, 0, 1'b0, 1'b1, 0, 5, "burst");
        run_frame(1'b1, 1, 2, 1'b0, 1'b0, 2, 0, "shp");
        check("shp_9", last_res, 9);

        set_w(-1, 0);
        run_frame(1'b0, 1, 0, 1'b0, 1'b0, 1, 0, "neg");
        check("neg_m18", last_res, -18);
        run_frame(1'b1, 1, 0, 1'b1, 1'b0, 1, 0, "relu");
        check("relu_0", last_res, 0);
        run_frame(1'b1, 1, 2, 1'b0, 1'b0, 2, 0, "shn");
        check("shn_m9", last_res, -9);

        set_w(127, 127);
        run_frame(1'b0, 1, 0, 1'b0, 1'b0, 127, 0, "satp");
        check("satp_127", last_res, 127);
        set_w(-128, 0);
        run_frame(1'b0, 1, 0, 1'b0, 1'b0, 127, 0, "satn");
        check("satn_m128", last_res, -128);

        for (int r = 0; r < 5; r++) begin
            kp = 1'($urandom_range(0, 1));
            if (!(kp && model_loaded)) begin
                for (int c = 0; c < CIN; c++)
                    for (int i = 0; i < KK; i++) wm[c][i] = rnd8();
                bm = rnd8();
            end
            run_frame(kp, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 12)),
                      1'($urandom_range(0, 1)), 1'b1, 0,
                      int'($urandom_range(0, 2)), "rand");
        end

        d0 = done_cnt;
        start = 1'b1;
        keep_weights = 1'b1;
        pix_count = 16'd1;
        @(negedge clk);
        start = 1'b0;
        keep_weights = 1'b0;
        for (int c = 0; c < CIN; c++)
            for (int i = 0; i < KK; i++) win[c][i] = rnd8();
        send_window(0);
        check("mid_run", bus.data_ready, 1);
        rst = 1'b0;
        model_loaded = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dr", bus.data_ready, 0);
        check("abort_wr", bus.weight_ready, 0);
        check("abort_ov", bus.out_valid, 0);
        check("abort_od", bus.out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_nodone", done_cnt - d0, 0);
        set_w(1, 0);
        run_frame(1'b1, 1, 0, 1'b0, 1'b0, 2, 0, "reload");
        check("reload_36", last_res, 36);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
